// File: rtl/sar_pkg.sv
// sar_pkg: shared types and constants for the SAR conversion sequencer.
// Holds the sequencer state encoding, default resolution and sample length,
// the counter-width helper and the register reset values.
package sar_pkg;

  localparam int NBIT_DEF          = 10;
  localparam int SAMPLE_CYCLES_DEF = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SAMPLE,
    S_COMP,
    S_STROBE,
    S_CRST,
    S_DONE
  } state_t;

  // Counter width for a count of n values; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Register reset values.
  localparam state_t STATE_RST   = S_IDLE;
  localparam logic   CKSB_RST    = 1'b0;
  localparam logic   CMP_CLK_RST = 1'b0;
  localparam logic   DV_RST      = 1'b0;
  localparam logic   BUSY_RST    = 1'b0;
  localparam logic   TMO_RST     = 1'b0;

endpackage

// File: rtl/sar_cmp_timer.sv
// sar_cmp_timer: counts comparator-evaluate cycles of the current bit and
// flags the cycle in which the count reaches CMP_TIMEOUT.
// Ports: clk_i/rst_i clock and async active-high reset; en_i high while the
// sequencer waits in COMP (low clears the count); hit_o high in the
// CMP_TIMEOUT-th consecutive COMP cycle. Exists only with SAR_CMP_TIMEOUT_EN.
`ifdef SAR_CMP_TIMEOUT_EN
module sar_cmp_timer
  import sar_pkg::*;
#(
  parameter int CMP_TIMEOUT = 15
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  output logic hit_o
);

  localparam int TW = cnt_w(CMP_TIMEOUT);

  logic [TW-1:0] cnt_q, cnt_d;

  // Count is zero in the first COMP cycle, so the hit lands on cycle CMP_TIMEOUT.
  always_comb begin
    cnt_d = en_i ? cnt_q + TW'(1) : '0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign hit_o = en_i && (cnt_q == TW'(CMP_TIMEOUT - 1));

endmodule
`endif

// File: rtl/sar_seq.sv
// sar_seq: SAR conversion sequencer; drives sample phase, comparator clock and
// MSB-first capture strobes, assembles decisions into a parallel code word.
// Ports: clk_i/rst_i (async active-high), start_i, cmp_p_i/cmp_n_i decisions;
// cksb_o, cmp_clk_o, cf_o, data_o, data_valid_o, busy_o, cmp_tmo_o (all registered).
// Optional macro SAR_CMP_TIMEOUT_EN: bounded comparator wait with sticky cmp_tmo_o.
module sar_seq
  import sar_pkg::*;
#(
  parameter int NBIT          = NBIT_DEF,
  parameter int SAMPLE_CYCLES = SAMPLE_CYCLES_DEF
`ifdef SAR_CMP_TIMEOUT_EN
  ,
  parameter int CMP_TIMEOUT   = 15
`endif
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            cmp_p_i,
  input  logic            cmp_n_i,
  output logic            cksb_o,
  output logic            cmp_clk_o,
  output logic [NBIT-1:0] cf_o,
  output logic [NBIT-1:0] data_o,
  output logic            data_valid_o,
  output logic            busy_o,
  output logic            cmp_tmo_o
);

  localparam int IDX_W  = cnt_w(NBIT);
  localparam int SCNT_W = cnt_w(SAMPLE_CYCLES);

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [SCNT_W-1:0] scnt_q, scnt_d;
  logic [NBIT-1:0]   res_q, res_d;
  logic [NBIT-1:0]   cf_q, cf_d;
  logic [NBIT-1:0]   data_q, data_d;
  logic              cksb_q, cksb_d;
  logic              cmp_clk_q, cmp_clk_d;
  logic              dv_q, dv_d;
  logic              busy_q, busy_d;
  logic              rdy;
  logic              tmo_hit;

  // Both comparator outputs high is a metastable/undecided condition.
  assign rdy = cmp_p_i ^ cmp_n_i;

`ifdef SAR_CMP_TIMEOUT_EN
  logic tmo_q, tmo_d;
  logic timer_hit;

  sar_cmp_timer #(.CMP_TIMEOUT(CMP_TIMEOUT)) u_cmp_timer (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (state_q == S_COMP),
    .hit_o (timer_hit)
  );

  assign tmo_hit   = timer_hit & ~rdy;
  assign cmp_tmo_o = tmo_q;
`else
  assign tmo_hit   = 1'b0;
  assign cmp_tmo_o = 1'b0;
`endif

  // Outputs are computed for the state being entered, so every output is a
  // flop and the CF edge lands while CMP_CLK is still high.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    scnt_d    = scnt_q;
    res_d     = res_q;
    cf_d      = cf_q;
    data_d    = data_q;
    cksb_d    = cksb_q;
    cmp_clk_d = cmp_clk_q;
    dv_d      = 1'b0;
    busy_d    = busy_q;
`ifdef SAR_CMP_TIMEOUT_EN
    tmo_d     = tmo_q;
`endif
    case (state_q)
      S_IDLE: begin
        cksb_d = 1'b0;
        cf_d   = '0;
        if (start_i) begin
          state_d = S_SAMPLE;
          busy_d  = 1'b1;
          scnt_d  = '0;
          res_d   = '0;
`ifdef SAR_CMP_TIMEOUT_EN
          tmo_d   = 1'b0;
`endif
        end
      end
      S_SAMPLE: begin
        if (scnt_q == SCNT_W'(SAMPLE_CYCLES - 1)) begin
          state_d   = S_COMP;
          cksb_d    = 1'b1;
          cmp_clk_d = 1'b1;
          idx_d     = IDX_W'(NBIT - 1);
        end else begin
          scnt_d = scnt_q + SCNT_W'(1);
        end
      end
      S_COMP: begin
        if (rdy || tmo_hit) begin
          // A timed-out bit resolves to 0.
          res_d[idx_q] = rdy & cmp_p_i;
          cf_d[idx_q]  = 1'b1;
          state_d      = S_STROBE;
`ifdef SAR_CMP_TIMEOUT_EN
          if (!rdy) tmo_d = 1'b1;
`endif
        end
      end
      S_STROBE: begin
        state_d   = S_CRST;
        cmp_clk_d = 1'b0;
      end
      S_CRST: begin
        // Exit on idx 0 before decrementing, so idx never wraps.
        if (idx_q == '0) begin
          state_d = S_DONE;
          data_d  = res_q;
          dv_d    = 1'b1;
          cksb_d  = 1'b0;
          cf_d    = '0;
          busy_d  = 1'b0;
        end else begin
          idx_d     = idx_q - IDX_W'(1);
          state_d   = S_COMP;
          cmp_clk_d = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= STATE_RST;
      idx_q     <= IDX_W'(NBIT - 1);
      scnt_q    <= '0;
      res_q     <= '0;
      cf_q      <= '0;
      data_q    <= '0;
      cksb_q    <= CKSB_RST;
      cmp_clk_q <= CMP_CLK_RST;
      dv_q      <= DV_RST;
      busy_q    <= BUSY_RST;
`ifdef SAR_CMP_TIMEOUT_EN
      tmo_q     <= TMO_RST;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      scnt_q    <= scnt_d;
      res_q     <= res_d;
      cf_q      <= cf_d;
      data_q    <= data_d;
      cksb_q    <= cksb_d;
      cmp_clk_q <= cmp_clk_d;
      dv_q      <= dv_d;
      busy_q    <= busy_d;
`ifdef SAR_CMP_TIMEOUT_EN
      tmo_q     <= tmo_d;
`endif
    end
  end

  assign cksb_o       = cksb_q;
  assign cmp_clk_o    = cmp_clk_q;
  assign cf_o         = cf_q;
  assign data_o       = data_q;
  assign data_valid_o = dv_q;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_sar_seq.sv
// tb_sar_seq: directed-plus-random bench for sar_seq with a behavioural
// comparator (per-bit decision delay) and an arithmetic latency/code model.
module tb_sar_seq;

  localparam int NBIT = 10;
  localparam int SC   = 4;
  localparam int TMO  = 15;

  logic            clk_i   = 1'b0;
  logic            rst_i   = 1'b0;
  logic            start_i = 1'b0;
  logic            cmp_p_i = 1'b0;
  logic            cmp_n_i = 1'b0;
  logic            cksb_o, cmp_clk_o, data_valid_o, busy_o, cmp_tmo_o;
  logic [NBIT-1:0] cf_o, data_o;

  sar_seq #(.NBIT(NBIT), .SAMPLE_CYCLES(SC)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .cmp_p_i      (cmp_p_i),
    .cmp_n_i      (cmp_n_i),
    .cksb_o       (cksb_o),
    .cmp_clk_o    (cmp_clk_o),
    .cf_o         (cf_o),
    .data_o       (data_o),
    .data_valid_o (data_valid_o),
    .busy_o       (busy_o),
    .cmp_tmo_o    (cmp_tmo_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  int edge_no = 0;

  // Comparator model state: per-bit decision delay (0 = never decides).
  int              kbit[NBIT];
  logic [NBIT-1:0] tgt = '0;
  logic [NBIT-1:0] prev_cf = '0;
  logic [NBIT-1:0] cf_before = '0;
  logic            prev_clk = 1'b0;
  int              nb = NBIT - 1;
  int              cur = NBIT - 1;
  int              ccnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_k(input int k);
    for (int i = 0; i < NBIT; i++) kbit[i] = k;
  endtask

  // One clock: observe 1 time unit after the edge, check CF behaviour, then
  // drive the comparator for the coming cycle.
  task automatic tick();
    bit b;
    @(posedge clk_i);
    edge_no++;
    #1;
    if (cmp_clk_o && !prev_clk) begin
      cur  = nb;
      nb   = nb - 1;
      ccnt = 0;
    end
    if (cf_o !== prev_cf) begin
      if ((cf_o & ~prev_cf) != '0) begin
        chk("cf_rise_bit", 32'(cf_o & ~prev_cf), 32'(1) << cur);
        chk("cmp_clk_at_cf_rise", 32'(cmp_clk_o), 32'(1));
      end
      if ((prev_cf & ~cf_o) != '0) chk("cf_clear_only_in_done", 32'(data_valid_o), 32'(1));
    end
    cf_before = prev_cf;
    prev_cf   = cf_o;
    prev_clk  = cmp_clk_o;
    if (!cksb_o) nb = NBIT - 1;
    if (cmp_clk_o) begin
      ccnt++;
      if (kbit[cur] != 0 && ccnt >= kbit[cur]) begin
        cmp_p_i = tgt[cur];
        cmp_n_i = ~tgt[cur];
      end else begin
        b = 1'($urandom_range(0, 1));
        cmp_p_i = b;
        cmp_n_i = b;
      end
    end else begin
      cmp_p_i = 1'b0;
      cmp_n_i = 1'b0;
    end
  endtask

  task automatic chk_zero(input string pfx);
    chk({pfx, "_cksb"}, 32'(cksb_o), 32'(0));
    chk({pfx, "_cmp_clk"}, 32'(cmp_clk_o), 32'(0));
    chk({pfx, "_cf"}, 32'(cf_o), 32'(0));
    chk({pfx, "_data"}, 32'(data_o), 32'(0));
    chk({pfx, "_data_valid"}, 32'(data_valid_o), 32'(0));
    chk({pfx, "_busy"}, 32'(busy_o), 32'(0));
    chk({pfx, "_cmp_tmo"}, 32'(cmp_tmo_o), 32'(0));
  endtask

  // Called 1 time unit after an edge: reset pulse well clear of both edges.
  task automatic do_rst(input string pfx);
    #2 rst_i = 1'b1;
    #1 chk_zero(pfx);
    #2 rst_i = 1'b0;
    prev_cf  = cf_o;
    prev_clk = 1'b0;
    nb       = NBIT - 1;
    cmp_p_i  = 1'b0;
    cmp_n_i  = 1'b0;
    tick();
    tick();
    chk({pfx, "_idle_data"}, 32'(data_o), 32'(0));
    chk({pfx, "_idle_busy"}, 32'(busy_o), 32'(0));
  endtask

  // Runs nconv conversions of 'code' with START held across them.
  task automatic conv(input logic [NBIT-1:0] code, input int nconv, input bit mid_pulse);
    int              exp_len, t0, seen, budget, kk;
    logic [NBIT-1:0] exp_data;
    bit              stuck;
    exp_len  = SC;
    exp_data = code;
    stuck    = 1'b0;
    for (int i = 0; i < NBIT; i++) begin
      kk = (kbit[i] == 0) ? TMO : kbit[i];
      exp_len += kk + 2;
      if (kbit[i] == 0) begin
        exp_data[i] = 1'b0;
        stuck       = 1'b1;
      end
    end
    tgt     = code;
    start_i = 1'b1;
    tick();
    t0 = edge_no;
    chk("busy_on_accept", 32'(busy_o), 32'(1));
    chk("tmo_clear_on_accept", 32'(cmp_tmo_o), 32'(0));
    if (nconv == 1) start_i = 1'b0;
    seen   = 0;
    budget = nconv * (exp_len + 2) + 20;
    while (seen < nconv && budget > 0) begin
      tick();
      budget--;
      if (mid_pulse && edge_no == t0 + 10) start_i = 1'b1;
      if (mid_pulse && edge_no == t0 + 11) start_i = 1'b0;
      if (data_valid_o) begin
        chk("done_edge", 32'(edge_no - t0), 32'(seen * (exp_len + 2) + exp_len));
        chk("data", 32'(data_o), 32'(exp_data));
        chk("busy_in_done", 32'(busy_o), 32'(0));
        chk("cksb_in_done", 32'(cksb_o), 32'(0));
        chk("cf_in_done", 32'(cf_o), 32'(0));
        chk("cf_full_before_done", 32'(cf_before), 32'({NBIT{1'b1}}));
`ifdef SAR_CMP_TIMEOUT_EN
        chk("cmp_tmo_at_done", 32'(cmp_tmo_o), 32'(stuck));
`else
        chk("cmp_tmo_at_done", 32'(cmp_tmo_o), 32'(0));
`endif
        seen++;
        if (seen == nconv) start_i = 1'b0;
      end
    end
    start_i = 1'b0;
    chk("conversions_completed", 32'(seen), 32'(nconv));
    tick();
    chk("data_valid_one_cycle", 32'(data_valid_o), 32'(0));
    tick();
    chk("no_queued_start", 32'(busy_o), 32'(0));
  endtask

  initial begin
    int got;
    int t0;
    set_k(1);

    // Reset state.
    #1 rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1 chk_zero("reset");
    #3 rst_i = 1'b0;
    repeat (3) tick();
    chk("idle_cksb", 32'(cksb_o), 32'(0));
    chk("idle_busy", 32'(busy_o), 32'(0));

    // Fast comparator, reference codes and extremes.
    conv(10'h2A5, 1, 1'b0);
    conv(10'h000, 1, 1'b0);
    conv(10'h3FF, 1, 1'b0);

    // Slow decision on bit 7 only.
    kbit[7] = 5;
    conv(NBIT'($urandom), 1, 1'b0);
    set_k(1);

    // Random codes and delays, with a START pulse mid-conversion on some.
    for (int n = 0; n < 4; n++) begin
      for (int i = 0; i < NBIT; i++) kbit[i] = $urandom_range(1, 4);
      conv(NBIT'($urandom), 1, n[0]);
    end
    set_k(1);

    // Comparator never decides on bit 3.
    kbit[3] = 0;
`ifdef SAR_CMP_TIMEOUT_EN
    conv(10'h3FF, 1, 1'b0);
    chk("cmp_tmo_sticky", 32'(cmp_tmo_o), 32'(1));
    set_k(1);
    conv(NBIT'($urandom), 1, 1'b0);
`else
    tgt     = 10'h3FF;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    got = 0;
    repeat (300) begin
      tick();
      if (data_valid_o) got++;
    end
    chk("stuck_no_done", 32'(got), 32'(0));
    chk("stuck_busy", 32'(busy_o), 32'(1));
    chk("stuck_cmp_clk", 32'(cmp_clk_o), 32'(1));
    chk("stuck_cf", 32'(cf_o), 32'(10'h3F0));
    do_rst("stuck_rst");
    set_k(1);
    conv(NBIT'($urandom), 1, 1'b0);
`endif

    // Reset in the middle of a conversion.
    tgt     = NBIT'($urandom);
    start_i = 1'b1;
    tick();
    t0      = edge_no;
    start_i = 1'b0;
    while (edge_no < t0 + 20) tick();
    do_rst("midconv_rst");
    conv(NBIT'($urandom), 1, 1'b0);

    // START held high: three back-to-back conversions.
    for (int i = 0; i < NBIT; i++) kbit[i] = $urandom_range(1, 3);
    conv(NBIT'($urandom), 3, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
